rv_to_fifo_read_buffer: RTL
===========================

Name: rv_to_fifo_read_buffer

Overview:
- Synthesizable output buffer that accepts a ready/valid producer stream and presents it as a show-ahead FIFO-read interface (rden/empty/data).
- It sits on the result side of an exported class, between the pipeline and the host or testbench consumer that polls empty and pulses rden.
- It is the receiving-end counterpart of the mailbox-to-ready/valid stimulus driver.

Parameters:
- WIDTH, 32, data bits per entry.
- DEPTH, 4, number of entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- valid_in  input  1  producer has a word on data_in.
- data_in  input  WIDTH  producer word.
- rdy_out  output  1  buffer can accept a word this cycle.
- rden_in  input  1  consumer pops the head entry.
- empty_out  output  1  no entry is available.
- data_out  output  WIDTH  head entry; meaningful only while empty_out=0.
- count_out  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- underflow_out  output  1  sticky flag: rden_in was seen while empty_out=1.

Behaviour:
- State:
  - Circular storage array of DEPTH x WIDTH.
  - wr_ptr and rd_ptr, $clog2(DEPTH) bits each, wrapping naturally from DEPTH-1 to 0.
  - count register, $clog2(DEPTH)+1 bits.
  - underflow flag.
- Reset (async assert, released synchronously by the environment):
  - wr_ptr=0, rd_ptr=0, count=0, underflow=0.
  - Storage is not reset.
  - While rst=1: rdy_out=0, empty_out=1, count_out=0, underflow_out=0. data_out is don't-care.
  - Reset mid-operation discards all stored entries immediately. The first push after reset lands at index 0.
- Outputs, combinational from registered state only:
  - empty_out = (count==0).
  - rdy_out = (count!=DEPTH) && !rst.
  - data_out = storage[rd_ptr].
  - No combinational path from valid_in or rden_in to any output.
- Push = valid_in && rdy_out:
  - Write storage[wr_ptr] <= data_in.
  - wr_ptr <= wr_ptr+1.
- valid_in while rdy_out=0: ignored. The producer must hold its data; the buffer does not capture it.
- Pop = rden_in && !empty_out:
  - rd_ptr <= rd_ptr+1.
- rden_in while empty_out=1:
  - No pointer or count change.
  - underflow <= 1, held until reset.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Latency:
  - A word pushed at edge N is visible at edge N+1: empty_out falls and data_out is valid in the cycle after the push cycle.
  - No same-cycle write-to-read bypass. A push into an empty buffer combined with rden_in in the same cycle counts as an underflow, and the push still occurs.
- Full:
  - rdy_out=0 when count==DEPTH, even if rden_in=1 in the same cycle. There is no full-bypass.
  - rdy_out rises the cycle after a pop from full.
- Simultaneous push and pop at 0<count<DEPTH: both pointers advance, count is unchanged, and the head updates to the next older entry.
- Ordering: strict FIFO. Data is never reordered, duplicated or dropped except by reset.
- Throughput: sustained 1 word/cycle when the producer and consumer are both continuously active and count is between 1 and DEPTH-1.

Test Plan:
- Reset check: hold rst for 10 cycles with valid_in=1 -> rdy_out=0, empty_out=1, count_out=0 throughout. After release, rdy_out=1 within 1 cycle.
- Fill and drain (DEPTH=4): push 0,5,10,15 with rden_in=0.
  - rdy_out=0 after the 4th push and count_out=4.
  - A 5th valid_in with data 20 is not accepted.
  - Popping 4 times returns 0,5,10,15, then empty_out=1 and 20 never appears.
- Wrap-around: push i*5 and pop concurrently for i=0..31 after pre-loading 2 entries.
  - Output is exactly the input sequence.
  - count_out stays 2.
  - Pointers wrap 8 times without a glitch.
- Full with simultaneous rden_in: at count=4, assert valid_in(99) and rden_in together.
  - The pop occurs and the push is rejected; count=3.
  - Next cycle rdy_out=1 and 99 is accepted.
- Underflow: pulse rden_in while empty.
  - underflow_out=1 the next cycle and stays 1.
  - count_out=0 and pointers unchanged.
  - Subsequent push/pop of 7 returns 7.
  - Reset clears underflow_out.
- Reset mid-stream: with count=3 (entries 1,2,3), assert rst asynchronously between edges.
  - empty_out=1 and count_out=0 immediately, before the next edge.
  - After release, push 42 -> first popped value is 42.

Source files
------------

// File: rtl/rv_to_fifo_read_buffer.sv
// Ready/valid sink presented as a show-ahead FIFO read port; a push is visible one cycle later (no bypass).
// Backpressure: rdy_out drops at full, even when the consumer pops in the same cycle.
module rv_to_fifo_read_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       rdy_out,
  input  logic                       rden_in,
  output logic                       empty_out,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       underflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             underflow;
  logic             push;
  logic             pop;

  // Outputs depend only on registered state (and rst), never on valid_in/rden_in.
  assign empty_out     = (count == '0);
  assign rdy_out       = (count != CW'(DEPTH)) && !rst;
  assign data_out      = mem[rd_ptr];
  assign count_out     = count;
  assign underflow_out = underflow;

  assign push = valid_in && rdy_out;
  assign pop  = rden_in && !empty_out;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (rden_in && empty_out) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
